// File: rtl/alu_issue.sv
// Issue/sequencing stage in front of a 32-bit combinational ALU: decodes one instruction,
// holds the ALU operands for the settle time, captures the result and hands it to writeback.
// Optional build macro: DIVZERO_TRAP_EN (div with rt==0 completes as illegal without using the ALU).
module alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int BASE_LAT   = 1,
    parameter int EXT_LAT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // decode side
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [5:0]            dec_opcode,
    input  logic [5:0]            dec_funct,
    input  logic [DATA_WIDTH-1:0] dec_rs_val,
    input  logic [DATA_WIDTH-1:0] dec_rt_val,
    input  logic [15:0]           dec_imm,
    // ALU side
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_iszero,
    // writeback side
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic                  wb_branch,
    output logic                  wb_taken,
    output logic                  wb_illegal,
    // debug
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // A producer holds valid and its payload until that edge; ready never depends on valid.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int MAX_LAT = (BASE_LAT > EXT_LAT) ? BASE_LAT : EXT_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_NOR = 4'b0100;
    localparam logic [3:0] C_MUL = 4'b0101;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_DIV = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_LUI = 4'b1011;
    localparam logic [3:0] C_BEQ = 4'b1100;
    localparam logic [3:0] C_BNE = 4'b1101;
    localparam logic [3:0] C_BLT = 4'b1110;
    localparam logic [3:0] C_BLE = 4'b1111;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    br_q;

    logic [3:0]              d_ctrl;
    logic [DATA_WIDTH-1:0]   d_in1;
    logic [DATA_WIDTH-1:0]   d_in2;
    logic                    d_legal;
    logic                    d_branch;
    logic                    d_ext;
    logic                    d_trap;
    logic [DATA_WIDTH-1:0]   imm_sx;
    logic [DATA_WIDTH-1:0]   imm_zx;

    assign imm_sx = {{(DATA_WIDTH-16){dec_imm[15]}}, dec_imm};
    assign imm_zx = {{(DATA_WIDTH-16){1'b0}}, dec_imm};

    // Instruction decode: ALU control code and operand selection.
    always_comb begin
        d_ctrl   = C_AND;
        d_in1    = dec_rs_val;
        d_in2    = dec_rt_val;
        d_legal  = 1'b0;
        d_branch = 1'b0;
        d_ext    = 1'b0;
        d_trap   = 1'b0;
        if (dec_opcode == 6'h00) begin
            case (dec_funct)
                6'h20: begin d_ctrl = C_ADD; d_legal = 1'b1; end
                6'h22: begin d_ctrl = C_SUB; d_legal = 1'b1; end
                6'h24: begin d_ctrl = C_AND; d_legal = 1'b1; end
                6'h25: begin d_ctrl = C_OR;  d_legal = 1'b1; end
                6'h26: begin d_ctrl = C_XOR; d_legal = 1'b1; end
                6'h27: begin d_ctrl = C_NOR; d_legal = 1'b1; end
                6'h00, 6'h02, 6'h03: begin
                    // Shifts operate on rt; the shift amount reaches the ALU inside imm[10:6].
                    d_ctrl  = (dec_funct == 6'h00) ? C_SLL :
                              (dec_funct == 6'h02) ? C_SRL : C_SRA;
                    d_in1   = dec_rt_val;
                    d_in2   = imm_zx;
                    d_legal = 1'b1;
                end
                6'h18: begin d_ctrl = C_MUL; d_legal = 1'b1; d_ext = 1'b1; end
                6'h1A: begin
                    d_ctrl  = C_DIV;
                    d_legal = 1'b1;
                    d_ext   = 1'b1;
`ifdef DIVZERO_TRAP_EN
                    d_trap  = (dec_rt_val == '0);
`endif
                end
                default: d_legal = 1'b0;
            endcase
        end else begin
            case (dec_opcode)
                6'h08: begin d_ctrl = C_ADD; d_in2 = imm_sx; d_legal = 1'b1; end
                6'h0C: begin d_ctrl = C_AND; d_in2 = imm_zx; d_legal = 1'b1; end
                6'h0D: begin d_ctrl = C_OR;  d_in2 = imm_zx; d_legal = 1'b1; end
                6'h0E: begin d_ctrl = C_XOR; d_in2 = imm_zx; d_legal = 1'b1; end
                6'h0F: begin d_ctrl = C_LUI; d_in2 = imm_zx; d_legal = 1'b1; end
                6'h04: begin d_ctrl = C_BEQ; d_legal = 1'b1; d_branch = 1'b1; end
                6'h05: begin d_ctrl = C_BNE; d_legal = 1'b1; d_branch = 1'b1; end
                6'h06: begin d_ctrl = C_BLT; d_legal = 1'b1; d_branch = 1'b1; end
                6'h07: begin d_ctrl = C_BLE; d_legal = 1'b1; d_branch = 1'b1; end
                default: d_legal = 1'b0;
            endcase
        end
    end

    // Gated with rst_n so the decode side sees not-ready while reset is asserted.
    assign dec_ready = (state == S_IDLE) && rst_n;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            br_q       <= 1'b0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_ctrl   <= '0;
            wb_valid   <= 1'b0;
            wb_result  <= '0;
            wb_branch  <= 1'b0;
            wb_taken   <= 1'b0;
            wb_illegal <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dec_valid) begin
                        if (!d_legal || d_trap) begin
                            // Rejected instructions never touch the ALU operands.
                            wb_valid   <= 1'b1;
                            wb_result  <= '0;
                            wb_branch  <= 1'b0;
                            wb_taken   <= 1'b0;
                            wb_illegal <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            alu_in1  <= d_in1;
                            alu_in2  <= d_in2;
                            alu_ctrl <= d_ctrl;
                            br_q     <= d_branch;
                            cnt      <= d_ext ? CNT_W'(EXT_LAT) : CNT_W'(BASE_LAT);
                            state    <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        wb_valid   <= 1'b1;
                        wb_result  <= alu_result;
                        wb_branch  <= br_q;
                        wb_taken   <= br_q & alu_iszero;
                        wb_illegal <= 1'b0;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: behavioural ALU plus an instruction-level reference model.
// Honours DIVZERO_TRAP_EN when the design is built with it.
module tb_alu_issue;

    localparam int DW       = 32;
    localparam int BASE_LAT = 1;
    localparam int EXT_LAT  = 4;

    logic          clk;
    logic          rst_n;
    logic          dec_valid;
    logic          dec_ready;
    logic [5:0]    dec_opcode;
    logic [5:0]    dec_funct;
    logic [DW-1:0] dec_rs_val;
    logic [DW-1:0] dec_rt_val;
    logic [15:0]   dec_imm;
    logic [DW-1:0] alu_in1;
    logic [DW-1:0] alu_in2;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_iszero;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_result;
    logic          wb_branch;
    logic          wb_taken;
    logic          wb_illegal;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_issue #(.DATA_WIDTH(DW), .BASE_LAT(BASE_LAT), .EXT_LAT(EXT_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_funct(dec_funct),
        .dec_rs_val(dec_rs_val), .dec_rt_val(dec_rt_val), .dec_imm(dec_imm),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_iszero(alu_iszero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result),
        .wb_branch(wb_branch), .wb_taken(wb_taken), .wb_illegal(wb_illegal),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural ALU ----------------
    logic [4:0] sh;
    always_comb begin
        sh         = alu_in2[10:6];
        alu_result = '0;
        case (alu_ctrl)
            4'b0010: alu_result = alu_in1 + alu_in2;
            4'b0110: alu_result = alu_in1 - alu_in2;
            4'b0000: alu_result = alu_in1 & alu_in2;
            4'b0001: alu_result = alu_in1 | alu_in2;
            4'b0011: alu_result = alu_in1 ^ alu_in2;
            4'b0100: alu_result = ~(alu_in1 | alu_in2);
            4'b1000: alu_result = alu_in1 << sh;
            4'b1001: alu_result = alu_in1 >> sh;
            4'b1010: alu_result = $signed(alu_in1) >>> sh;
            4'b0101: alu_result = alu_in1 * alu_in2;
            4'b0111: alu_result = (alu_in2 == '0) ? '1 : alu_in1 / alu_in2;
            4'b1011: alu_result = alu_in2 << 16;
            default: alu_result = alu_in1 - alu_in2;
        endcase
        case (alu_ctrl)
            4'b1100: alu_iszero = (alu_in1 == alu_in2);
            4'b1101: alu_iszero = (alu_in1 != alu_in2);
            4'b1110: alu_iszero = ($signed(alu_in1) <  $signed(alu_in2));
            4'b1111: alu_iszero = ($signed(alu_in1) <= $signed(alu_in2));
            default: alu_iszero = (alu_result == '0);
        endcase
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          legal;
        logic          chk;
        logic          branch;
        logic          taken;
        logic [3:0]    ctrl;
        logic [DW-1:0] in1;
        logic [DW-1:0] in2;
        logic [DW-1:0] res;
        logic [7:0]    lat;
    } exp_t;

    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                                   input logic [15:0] imm);
        exp_t        e;
        logic [31:0] sx;
        logic [31:0] zx;
        int          sa;
        sx = {{16{imm[15]}}, imm};
        zx = {16'h0, imm};
        sa = int'(imm[10:6]);
        e = '0;
        e.legal = 1'b1;
        e.chk   = 1'b1;
        e.in1   = rs;
        e.in2   = rt;
        e.lat   = 8'(BASE_LAT);
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin e.ctrl = 4'b0010; e.res = rs + rt; end
                6'h22: begin e.ctrl = 4'b0110; e.res = rs - rt; end
                6'h24: begin e.ctrl = 4'b0000; e.res = rs & rt; end
                6'h25: begin e.ctrl = 4'b0001; e.res = rs | rt; end
                6'h26: begin e.ctrl = 4'b0011; e.res = rs ^ rt; end
                6'h27: begin e.ctrl = 4'b0100; e.res = ~(rs | rt); end
                6'h00: begin e.ctrl = 4'b1000; e.in1 = rt; e.in2 = zx; e.res = rt << sa; end
                6'h02: begin e.ctrl = 4'b1001; e.in1 = rt; e.in2 = zx; e.res = rt >> sa; end
                6'h03: begin e.ctrl = 4'b1010; e.in1 = rt; e.in2 = zx; e.res = $signed(rt) >>> sa; end
                6'h18: begin e.ctrl = 4'b0101; e.res = rs * rt; e.lat = 8'(EXT_LAT); end
                6'h1A: begin
                    e.ctrl = 4'b0111;
                    e.lat  = 8'(EXT_LAT);
                    if (rt == 0) begin
`ifdef DIVZERO_TRAP_EN
                        e.legal = 1'b0;
`else
                        e.chk = 1'b0;
`endif
                    end else begin
                        e.res = rs / rt;
                    end
                end
                default: e.legal = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin e.ctrl = 4'b0010; e.in2 = sx; e.res = rs + sx; end
                6'h0C: begin e.ctrl = 4'b0000; e.in2 = zx; e.res = rs & zx; end
                6'h0D: begin e.ctrl = 4'b0001; e.in2 = zx; e.res = rs | zx; end
                6'h0E: begin e.ctrl = 4'b0011; e.in2 = zx; e.res = rs ^ zx; end
                6'h0F: begin e.ctrl = 4'b1011; e.in2 = zx; e.res = {imm, 16'h0}; end
                6'h04: begin e.ctrl = 4'b1100; e.branch = 1'b1; e.taken = (rs == rt); end
                6'h05: begin e.ctrl = 4'b1101; e.branch = 1'b1; e.taken = (rs != rt); end
                6'h06: begin e.ctrl = 4'b1110; e.branch = 1'b1; e.taken = ($signed(rs) <  $signed(rt)); end
                6'h07: begin e.ctrl = 4'b1111; e.branch = 1'b1; e.taken = ($signed(rs) <= $signed(rt)); end
                default: e.legal = 1'b0;
            endcase
            if (e.branch) e.res = rs - rt;
        end
        if (!e.legal) begin
            e.res    = '0;
            e.chk    = 1'b1;
            e.branch = 1'b0;
            e.taken  = 1'b0;
            e.lat    = 8'd0;
        end
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    logic [3:0]    last_ctrl;
    logic [DW-1:0] last_in1;
    logic [DW-1:0] last_in2;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at a falling edge with the stage idle again.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                         input logic [15:0] imm, input int hold,
                         output logic [DW-1:0] got);
        exp_t          e;
        int            n;
        logic [DW-1:0] exp_res;
        e = model(op, fn, rs, rt, imm);
        exp_q.push_back(e.res);
        dec_opcode = op;
        dec_funct  = fn;
        dec_rs_val = rs;
        dec_rt_val = rt;
        dec_imm    = imm;
        dec_valid  = 1'b1;
        check("dec_ready_idle", DW'(dec_ready), 1);
        @(posedge clk);
        @(negedge clk);
        dec_valid = 1'b0;
        n = 1;
        while (!wb_valid && n < 30) begin
            check("dec_ready_busy", DW'(dec_ready), 0);
            check("alu_ctrl", DW'(alu_ctrl), DW'(e.ctrl));
            check("alu_in1", alu_in1, e.in1);
            check("alu_in2", alu_in2, e.in2);
            @(negedge clk);
            n++;
        end
        check("latency", DW'(n), DW'(e.lat) + 1);
        check("wb_valid", DW'(wb_valid), 1);
        check("wb_illegal", DW'(wb_illegal), DW'(!e.legal));
        check("wb_branch", DW'(wb_branch), DW'(e.branch));
        check("wb_taken", DW'(wb_taken), DW'(e.taken));
        exp_res = exp_q.pop_front();
        if (e.chk) check("wb_result", wb_result, exp_res);
        if (!e.legal) begin
            check("alu_ctrl_kept", DW'(alu_ctrl), DW'(last_ctrl));
            check("alu_in1_kept", alu_in1, last_in1);
            check("alu_in2_kept", alu_in2, last_in2);
        end else begin
            last_ctrl = e.ctrl;
            last_in1  = e.in1;
            last_in2  = e.in2;
        end
        got = wb_result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", DW'(wb_valid), 1);
            check("hold_result", wb_result, got);
            check("hold_dec_ready", DW'(dec_ready), 0);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        check("release_valid", DW'(wb_valid), 0);
        check("release_dec_ready", DW'(dec_ready), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dec_ready"}, DW'(dec_ready), 0);
        check({tag, "_wb_valid"}, DW'(wb_valid), 0);
        check({tag, "_wb_result"}, wb_result, 0);
        check({tag, "_wb_flags"}, DW'({wb_branch, wb_taken, wb_illegal}), 0);
        check({tag, "_alu_ctrl"}, DW'(alu_ctrl), 0);
        check({tag, "_alu_in1"}, alu_in1, 0);
        check({tag, "_alu_in2"}, alu_in2, 0);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] r_fn [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00, 6'h02, 6'h03, 6'h18, 6'h1A};
    logic [5:0] i_op [9]  = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h06, 6'h07};
    logic [5:0] bad_op [4] = '{6'h3F, 6'h01, 6'h10, 6'h2A};

    initial begin
        logic [DW-1:0] got;
        logic [5:0]    op;
        logic [5:0]    fn;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        int            sel;

        rst_n      = 1'b0;
        dec_valid  = 1'b0;
        wb_ready   = 1'b0;
        dec_opcode = '0;
        dec_funct  = '0;
        dec_rs_val = '0;
        dec_rt_val = '0;
        dec_imm    = '0;
        last_ctrl  = '0;
        last_in1   = '0;
        last_in2   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        #1;
        check("post_reset_dec_ready", DW'(dec_ready), 1);
        check("post_reset_wb_valid", DW'(wb_valid), 0);
        @(negedge clk);

        // add 5 + 7
        issue(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 0, got);
        check("add_const", got, 32'd12);
        // sra 0x80000000 by 4
        issue(6'h00, 6'h03, 32'h0, 32'h8000_0000, 16'h0100, 1, got);
        check("sra_const", got, 32'hF800_0000);
        // branches on equal operands
        issue(6'h04, 6'h00, 32'd3, 32'd3, 16'h0000, 0, got);
        check("beq_taken", DW'(wb_taken), 1);
        issue(6'h05, 6'h00, 32'd3, 32'd3, 16'h0000, 0, got);
        check("bne_not_taken", DW'(wb_taken), 0);
        // mul with writeback stalled for 5 cycles
        issue(6'h00, 6'h18, 32'd6, 32'd7, 16'h0000, 5, got);
        check("mul_const", got, 32'd42);
        // div by zero and an unknown opcode
        issue(6'h00, 6'h1A, 32'd9, 32'd0, 16'h0000, 0, got);
`ifdef DIVZERO_TRAP_EN
        check("divzero_illegal", DW'(wb_illegal), 1);
`else
        check("divzero_legal", DW'(wb_illegal), 0);
`endif
        issue(6'h3F, 6'h00, 32'd1, 32'd2, 16'h1234, 0, got);
        check("op3f_result", got, 32'd0);
        // addi with negative immediate, lui, blt/ble signed compare
        issue(6'h08, 6'h00, 32'd10, 32'd0, 16'hFFFE, 0, got);
        check("addi_neg", got, 32'd8);
        issue(6'h0F, 6'h00, 32'd0, 32'd0, 16'hABCD, 0, got);
        check("lui_const", got, 32'hABCD_0000);
        issue(6'h06, 6'h00, 32'hFFFF_FFFF, 32'd1, 16'h0000, 0, got);
        check("blt_signed", DW'(wb_taken), 1);
        issue(6'h07, 6'h00, 32'd1, 32'hFFFF_FFFF, 16'h0000, 0, got);
        check("ble_signed", DW'(wb_taken), 0);

        // randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) begin
                op = 6'h00;
                fn = r_fn[$urandom_range(0, 10)];
            end else if (sel < 9) begin
                op = i_op[$urandom_range(0, 8)];
                fn = 6'($urandom);
            end else begin
                op = bad_op[$urandom_range(0, 3)];
                fn = 6'($urandom);
            end
            rs = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 8)) : DW'($urandom);
            rt = ($urandom_range(0, 5) == 0) ? '0 :
                 ($urandom_range(0, 2) == 0) ? rs : DW'($urandom);
            issue(op, fn, rs, rt, 16'($urandom), $urandom_range(0, 3), got);
        end

        // asynchronous reset in the middle of a mul
        dec_opcode = 6'h00;
        dec_funct  = 6'h18;
        dec_rs_val = 32'd11;
        dec_rt_val = 32'd13;
        dec_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dec_valid = 1'b0;
        check("mid_exec_busy", DW'(dec_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease_dec_ready", DW'(dec_ready), 1);
        check("rerelease_wb_valid", DW'(wb_valid), 0);
        last_ctrl = '0;
        last_in1  = '0;
        last_in2  = '0;
        @(negedge clk);
        issue(6'h00, 6'h22, 32'd20, 32'd5, 16'h0000, 0, got);
        check("sub_after_reset", got, 32'd15);
        // illegal right after reset keeps the ALU operands from the sub
        issue(6'h00, 6'h3F, 32'd1, 32'd1, 16'h0000, 0, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
